// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding and operation-select constants.
package serial_addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_cell.sv
// One-bit full adder/subtractor built from two half-adder/half-subtractor
// stages whose carry/borrow outputs are ORed together.
module addsub_cell
  import serial_addsub_ctrl_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic sub,
  output logic d,
  output logic cout
);

  logic w_sub;
  logic w_d1;
  logic w_c1;
  logic w_c2;

  assign w_sub = (sub == OP_SUB);

  // In subtract mode each stage's carry becomes a borrow: the minuend is inverted.
  assign w_d1 = x ^ y;
  assign w_c1 = (w_sub ? ~x : x) & y;

  assign d    = w_d1 ^ cin;
  assign w_c2 = (w_sub ? ~w_d1 : w_d1) & cin;

  assign cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial A+B / A-B: operands shift out LSB first through a single 1-bit
// cell, the result shifts in from the MSB end, one bit per clock.
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Handshake: a request is taken on a rising edge where start=1 and ready=1;
  // done is a one-cycle pulse during which result/cout are valid, and both
  // hold until the next accepted request.

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_shift;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;

  logic             w_d;
  logic             w_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_shift  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == LAST_BIT) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  addsub_cell u_cell (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .cin  (r_carry),
    .sub  (r_op),
    .d    (w_d),
    .cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_op     <= op;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_shift) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_carry  <= w_cout;
      r_cnt    <= r_cnt + CW'(1);
      r_result <= {w_d, r_result[WIDTH-1:1]};
    end
  end

  assign ready     = (r_state == IDLE);
  assign busy      = (r_state == SHIFT) || (r_state == DONE);
  assign done      = (r_state == DONE);
  assign result    = r_result;
  assign cout      = r_carry;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH=8): directed, random,
// held-start, mid-operation reset and back-to-back scenarios.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  wire          ready;
  wire          busy;
  wire          done;
  wire  [W-1:0] result;
  wire          cout;
  wire  [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
    .dbg_state (dbg_state)
  );

  // Reference: plain modulo arithmetic; top bit is carry (add) or borrow (sub).
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic o);
    logic [W:0]   r;
    logic [W-1:0] diff;
    if (o == 1'b0) begin
      r = {1'b0, x} + {1'b0, y};
    end else begin
      diff = x - y;
      r    = {(x < y), diff};
    end
    return r;
  endfunction

  // Called at a falling edge with the DUT idle; returns #1 after the accept edge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic o, input bit hold);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL launch_ready: got %b expected 1", ready);
    end
    a     = x;
    b     = y;
    op    = o;
    start = 1'b1;
    exp_q.push_back(model(x, y, o));
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Walks edges 1..W+1 after an accept, checking the done pulse position,
  // status flags and the final result; ends at the falling edge in IDLE.
  task automatic finish(input bit scramble, input string name);
    logic [W:0] exp;
    exp = exp_q.pop_front();
    for (int i = 1; i <= W + 1; i++) begin
      @(posedge clk);
      if (scramble) begin
        #1;
        a  = W'($urandom);
        b  = W'($urandom);
        op = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      checks++;
      if (done !== (i == W)) begin
        failures++;
        $display("FAIL %s done edge %0d: got %b expected %b", name, i, done, (i == W));
      end
      if (i <= W) begin
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
          failures++;
          $display("FAIL %s flags edge %0d: got busy=%b ready=%b expected busy=1 ready=0",
                   name, i, busy, ready);
        end
      end else begin
        checks++;
        if (busy !== 1'b0 || ready !== 1'b1) begin
          failures++;
          $display("FAIL %s idle flags: got busy=%b ready=%b expected busy=0 ready=1",
                   name, busy, ready);
        end
      end
      if (i >= W) begin
        checks++;
        if ({cout, result} !== exp) begin
          failures++;
          $display("FAIL %s result edge %0d: got cout=%b result=%h expected cout=%b result=%h",
                   name, i, cout, result, exp[W], exp[W-1:0]);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        result !== '0 || cout !== 1'b0) begin
      failures++;
      $display("FAIL %s: got ready=%b busy=%b done=%b result=%h cout=%b expected 1 0 0 00 0",
               name, ready, busy, done, result, cout);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                          input logic [W-1:0] want_r, input logic want_c, input string name);
    launch(x, y, o, 1'b0);
    finish(1'b0, name);
    checks++;
    if (result !== want_r || cout !== want_c) begin
      failures++;
      $display("FAIL %s const: got result=%h cout=%b expected result=%h cout=%b",
               name, result, cout, want_r, want_c);
    end
  endtask

  task automatic test_directed();
    directed(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, "add_nocarry");
    directed(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_wrap");
    directed(8'h10, 8'h01, 1'b1, 8'h0F, 1'b0, "sub_noborrow");
    directed(8'h00, 8'h01, 1'b1, 8'hFF, 1'b1, "sub_borrow");
    directed(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, "add_max");
    directed(8'h80, 8'h80, 1'b1, 8'h00, 1'b0, "sub_equal");
  endtask

  task automatic test_ignored_start();
    launch(8'h12, 8'h34, 1'b0, 1'b1);
    finish(1'b1, "held_start");
    launch(8'hA5, 8'h5A, 1'b1, 1'b0);
    finish(1'b0, "after_held");
  endtask

  task automatic test_reset_mid();
    logic [W:0] dropped;
    launch(8'h35, 8'h4A, 1'b0, 1'b0);
    dropped = exp_q.pop_front();
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_async");
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("reset_mid_held");
    end
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_nodone cycle %0d: got %b expected 0 (dropped %h)",
                 i, done, dropped);
      end
    end
    directed(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, "after_reset_mid");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         o;
      bit           scr;
      x   = W'($urandom);
      y   = W'($urandom);
      o   = 1'($urandom_range(0, 1));
      scr = 1'($urandom_range(0, 1));
      launch(x, y, o, scr);
      finish(scr, "random");
      start = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) begin
      launch(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      finish(1'b0, "back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
